// File: rtl/csr_pkg.sv
// Shared CSR addresses, operation encodings and field constants for the
// machine-mode CSR file.
package csr_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS  = 12'h300,
    CSR_MISA     = 12'h301,
    CSR_MTVEC    = 12'h305,
    CSR_MSCRATCH = 12'h340,
    CSR_MEPC     = 12'h341,
    CSR_MCAUSE   = 12'h342,
    CSR_MCYCLE   = 12'hB00,
    CSR_MINSTRET = 12'hB02,
    CSR_MHARTID  = 12'hF14
  } csr_addr_e;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam logic [63:0] MSTATUS_WMASK    = 64'h0000_0000_0000_0088;
  localparam logic [1:0]  MSTATUS_MPP_M    = 2'b11;

  // MXL sits in the top two bits of the native width; I extension is bit 8.
  function automatic logic [63:0] MISA_VALUE(input int unsigned xlen);
    logic [63:0] v;
    v = 64'h0000_0000_0000_0100;
    if (xlen == 64) begin
      v[63:62] = 2'b10;
    end else begin
      v[31:30] = 2'b01;
    end
    return v;
  endfunction

endpackage

// File: rtl/csr_if.sv
// CSR request/response bus between the execute stage (master) and the
// CSR file (slave).
interface csr_if #(
  parameter int XLEN = 64
);
  logic [11:0]     csr_addr;
  logic            csr_read;
  logic            csr_write;
  logic [1:0]      csr_op;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;

  modport master (
    output csr_addr, csr_read, csr_write, csr_op, csr_wdata,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_addr, csr_read, csr_write, csr_op, csr_wdata,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/csr_counter.sv
// Free-running XLEN-wide counter with a load port that overrides the
// increment in the same cycle; wraps silently.
module csr_counter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            i_inc,
  input  logic            i_we,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_count
);
  logic [XLEN-1:0] r_count;

  // Load wins over increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (i_we) begin
      r_count <= i_wdata;
    end else if (i_inc) begin
      r_count <= r_count + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file and trap unit. Defining CSR_COUNTERS_EN builds the
// mcycle/minstret counters; otherwise their addresses decode as unknown.
module csr_file
  import csr_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  csr_if.slave            csr_bus,
  input  logic            stall,
  input  logic            exception_occurred,
  input  logic [XLEN-1:0] exception_pc,
  input  logic [3:0]      exception_cause,
  input  logic            mret,
  input  logic            instret,
  output logic            trap_redirect,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] mret_target,
  output logic            mie_out
);
  logic [XLEN-1:0] r_mstatus;
  logic [XLEN-1:2] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:2] r_mepc;
  logic [3:0]      r_mcause;
  logic            r_trap_redirect;

  logic [XLEN-1:0] w_mstatus_nxt;
  logic [XLEN-1:2] w_mtvec_nxt;
  logic [XLEN-1:0] w_mscratch_nxt;
  logic [XLEN-1:2] w_mepc_nxt;
  logic [3:0]      w_mcause_nxt;

  logic [XLEN-1:0] w_misa;
  logic [XLEN-1:0] w_wmask;
  logic [XLEN-1:0] w_rdata;
  logic [XLEN-1:0] w_wval;
  logic            w_known;
  logic            w_readonly;
  logic            w_illegal;
  logic            w_we;
  logic            w_unused;

  assign w_misa  = XLEN'(MISA_VALUE(XLEN));
  assign w_wmask = MSTATUS_WMASK[XLEN-1:0];

`ifdef CSR_COUNTERS_EN
  logic [XLEN-1:0] w_mcycle;
  logic [XLEN-1:0] w_minstret;
  logic            w_mcycle_we;
  logic            w_minstret_we;

  assign w_mcycle_we   = w_we && (csr_bus.csr_addr == CSR_MCYCLE);
  assign w_minstret_we = w_we && (csr_bus.csr_addr == CSR_MINSTRET);

  csr_counter #(.XLEN(XLEN)) u_mcycle (
    .clk     (clk),
    .resetn  (resetn),
    .i_inc   (1'b1),
    .i_we    (w_mcycle_we),
    .i_wdata (w_wval),
    .o_count (w_mcycle)
  );

  csr_counter #(.XLEN(XLEN)) u_minstret (
    .clk     (clk),
    .resetn  (resetn),
    .i_inc   (instret),
    .i_we    (w_minstret_we),
    .i_wdata (w_wval),
    .o_count (w_minstret)
  );

  assign w_unused = &{1'b0, exception_pc[1:0]};
`else
  assign w_unused = &{1'b0, exception_pc[1:0], instret};
`endif

  // Read decode; the readback view also serves as the old value for RS/RC.
  always_comb begin
    w_rdata    = '0;
    w_known    = 1'b1;
    w_readonly = 1'b0;
    case (csr_bus.csr_addr)
      CSR_MSTATUS: begin
        w_rdata        = r_mstatus;
        w_rdata[12:11] = MSTATUS_MPP_M;
      end
      CSR_MISA: begin
        w_rdata    = w_misa;
        w_readonly = 1'b1;
      end
      CSR_MTVEC:    w_rdata = {r_mtvec, 2'b00};
      CSR_MSCRATCH: w_rdata = r_mscratch;
      CSR_MEPC:     w_rdata = {r_mepc, 2'b00};
      CSR_MCAUSE:   w_rdata = {{(XLEN-4){1'b0}}, r_mcause};
      CSR_MHARTID:  w_rdata = '0;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:   w_rdata = w_mcycle;
      CSR_MINSTRET: w_rdata = w_minstret;
`endif
      default:      w_known = 1'b0;
    endcase
  end

  assign w_illegal = ((csr_bus.csr_read | csr_bus.csr_write) & ~w_known) |
                     (csr_bus.csr_write & (w_readonly | (csr_bus.csr_addr[11:10] == 2'b11)));

  assign w_we = csr_bus.csr_write & ~stall & ~w_illegal & ~exception_occurred &
                (csr_bus.csr_op != CSR_OP_NONE);

  // Read-modify-write operand.
  always_comb begin
    w_wval = w_rdata;
    case (csr_bus.csr_op)
      CSR_OP_RW: w_wval = csr_bus.csr_wdata;
      CSR_OP_RS: w_wval = w_rdata | csr_bus.csr_wdata;
      CSR_OP_RC: w_wval = w_rdata & ~csr_bus.csr_wdata;
      default:   w_wval = w_rdata;
    endcase
  end

  // Next state: CSR write first, then mret, then trap, so later steps win.
  always_comb begin
    w_mstatus_nxt  = r_mstatus;
    w_mtvec_nxt    = r_mtvec;
    w_mscratch_nxt = r_mscratch;
    w_mepc_nxt     = r_mepc;
    w_mcause_nxt   = r_mcause;
    if (w_we) begin
      case (csr_bus.csr_addr)
        CSR_MSTATUS:  w_mstatus_nxt  = w_wval & w_wmask;
        CSR_MTVEC:    w_mtvec_nxt    = w_wval[XLEN-1:2];
        CSR_MSCRATCH: w_mscratch_nxt = w_wval;
        CSR_MEPC:     w_mepc_nxt     = w_wval[XLEN-1:2];
        CSR_MCAUSE:   w_mcause_nxt   = w_wval[3:0];
        default:      w_mscratch_nxt = r_mscratch;
      endcase
    end else begin
      w_mscratch_nxt = r_mscratch;
    end
    if (exception_occurred) begin
      w_mepc_nxt                      = exception_pc[XLEN-1:2];
      w_mcause_nxt                    = exception_cause;
      w_mstatus_nxt[MSTATUS_MPIE_BIT] = r_mstatus[MSTATUS_MIE_BIT];
      w_mstatus_nxt[MSTATUS_MIE_BIT]  = 1'b0;
    end else if (mret) begin
      w_mstatus_nxt[MSTATUS_MIE_BIT]  = r_mstatus[MSTATUS_MPIE_BIT];
      w_mstatus_nxt[MSTATUS_MPIE_BIT] = 1'b1;
    end else begin
      w_mcause_nxt = w_mcause_nxt;
    end
  end

  // CSR and trap state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mstatus       <= '0;
      r_mtvec         <= '0;
      r_mscratch      <= '0;
      r_mepc          <= '0;
      r_mcause        <= 4'd0;
      r_trap_redirect <= 1'b0;
    end else begin
      r_mstatus       <= w_mstatus_nxt;
      r_mtvec         <= w_mtvec_nxt;
      r_mscratch      <= w_mscratch_nxt;
      r_mepc          <= w_mepc_nxt;
      r_mcause        <= w_mcause_nxt;
      r_trap_redirect <= exception_occurred;
    end
  end

  assign csr_bus.csr_rdata   = w_rdata;
  assign csr_bus.csr_illegal = w_illegal;
  assign trap_redirect       = r_trap_redirect;
  assign trap_vector         = {r_mtvec, 2'b00};
  assign mret_target         = {r_mepc, 2'b00};
  assign mie_out             = r_mstatus[MSTATUS_MIE_BIT];
endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
Machine-mode CSR file and trap unit for the RV64 pipeline. It is the responder side of the execute stage's CSR request interface: it returns csr_rdata, commits CSR writes, and records the exception outputs as trap state. It supplies trap-vector and mret-target redirects to fetch, and holds the mcycle/minstret counters.

Parameters:
XLEN, 64, datapath width; 32 and 64 supported.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
csr_addr  in  12  CSR address from execute
csr_read  in  1  read request
csr_write  in  1  write request
csr_op  in  2  funct3[1:0]: 01 RW, 10 RS (set bits), 11 RC (clear bits)
csr_wdata  in  XLEN  write operand (rs1 value or zimm)
stall  in  1  blocks CSR write commit and counter writes
csr_rdata  out  XLEN  combinational read data
csr_illegal  out  1  combinational: unknown address, or write to read-only
exception_occurred  in  1  trap request, one-cycle pulse
exception_pc  in  XLEN  faulting PC
exception_cause  in  4  cause code
mret  in  1  mret retiring, one-cycle pulse
instret  in  1  instruction retired pulse
trap_redirect  out  1  registered; one cycle after trap entry
trap_vector  out  XLEN  {mtvec[XLEN-1:2],2'b00}
mret_target  out  XLEN  mepc
mie_out  out  1  mstatus.MIE

Behaviour:
- Reset values: all CSRs 0 except hardwired fields; trap_redirect 0, mie_out 0. csr_rdata and csr_illegal follow from a reset state of csr_addr.
- Address map:
  - 0x300 mstatus: MIE bit 3 and MPIE bit 7 writable; MPP [12:11] reads 2'b11; all other bits read 0.
  - 0x301 misa: read-only. MXL = 2 at [XLEN-1:XLEN-2] when XLEN=64, 1 when XLEN=32; bit 8 (I) set.
  - 0x305 mtvec: bits [1:0] read 0 (direct mode only).
  - 0x340 mscratch: full width.
  - 0x341 mepc: bits [1:0] read 0.
  - 0x342 mcause: bit XLEN-1 is 0; cause in [3:0]; other bits 0.
  - 0xF14 mhartid: reads 0.
  - 0xB00 mcycle, 0xB02 minstret: gated by CSR_COUNTERS_EN.
- Read: csr_rdata is a zero-latency combinational function of csr_addr and current CSR state. Unknown address reads 0 and raises csr_illegal when csr_read or csr_write is set.
- Write: commits at the posedge when csr_write && !stall && !csr_illegal && !exception_occurred.
  - New value = old value with the writable-bit mask applied:
    - RW: wdata
    - RS: old | wdata
    - RC: old & ~wdata
  - csr_op 00: no write.
  - csr_addr[11:10] == 2'b11 with csr_write set: csr_illegal = 1, no state change.
  - csr_rdata returns the pre-write value (read-modify-write semantics).
- Trap entry on exception_occurred, applied at the next edge regardless of stall:
  - mepc <= exception_pc with [1:0] cleared
  - mcause <= cause
  - MPIE <= MIE; MIE <= 0
  - trap_redirect <= 1 for exactly one cycle
- mret, when no exception is present that cycle: MIE <= MPIE, MPIE <= 1. mret_target is always mepc.
- Priority: trap > mret > CSR write. If trap and write coincide, the write is dropped. If mret and a write to mstatus coincide, mret wins for MIE/MPIE.
- Counters: mcycle += 1 every non-reset cycle; minstret += instret. Both wrap at 2^XLEN − 1 → 0 with no flag. A committing write to a counter overrides that cycle's increment.
- Reset asserted mid-operation: all state returns to reset values immediately; a pending trap_redirect is cancelled.

Optional Feature:
CSR_COUNTERS_EN
- Defined: mcycle and minstret exist as above.
- Undefined: counter registers are not built; 0xB00 and 0xB02 behave as unknown addresses (read 0, csr_illegal = 1 on access). The instret input is ignored.

Decomposition:
- Package csr_pkg holds:
  - csr_addr_e: enum of supported CSR addresses
  - csr_op_e: RW/RS/RC
  - MSTATUS_MIE_BIT = 3, MSTATUS_MPIE_BIT = 7
  - MSTATUS_WMASK
  - MISA_VALUE(XLEN)
- One sub-module: csr_counter (XLEN-wide, increment enable, write port with priority over increment), instantiated twice under CSR_COUNTERS_EN.

Test Plan:
1. Reset, then read 0x300 → rdata 0x1800, illegal 0. Read 0x301 (XLEN=64) → 0x8000_0000_0000_0100. Read 0xF14 → 0.
2. RW 0x340 with 0xDEAD_BEEF → rdata returns old value 0. Next read → 0xDEAD_BEEF. RS 0x0F → 0xDEAD_BEEF. RC 0xF0 → 0xDEAD_BE0F.
3. Set MIE; exception at pc 0x8000_0102, cause 2, mtvec 0x1001 → next cycle:
   - mepc 0x8000_0100, mcause 2
   - mstatus 0x1880 (MPIE = 1, MIE = 0)
   - trap_redirect high for one cycle; trap_vector 0x1000
4. mret pulse → mstatus 0x1888; mret_target 0x8000_0100.
5. Write 0xF14 → illegal 1, value unchanged. Write to 0x7C0 → illegal 1, rdata 0. Write with stall high → no change.
6. Trap coincident with RW 0x340 = 5 → mscratch unchanged. RW mcycle = 0xFFFF_FFFF_FFFF_FFFF → wraps to 0 two cycles later. Without CSR_COUNTERS_EN, read 0xB00 → illegal 1.
